// File: rtl/ks10_ramfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ks10_ramfile_pkg
//  Description : Shared types and constants for the KS-10 RAMFILE unit:
//                address-select encodings, RAMFILE state encodings, the
//                structural widths and the odd-parity helper used when the
//                optional parity bit (RAMFILE_PARITY_EN) is built in.
//  Revision    : 1.0  initial release
// ============================================================================
package ks10_ramfile_pkg;

    localparam int c_ADDR_W = 10;   // RAMFILE address width (1024 words)
    localparam int c_DATA_W = 36;   // KS-10 word
    localparam int c_BLK_W  = 3;    // AC block number
    localparam int c_NUM_W  = 4;    // AC / XR number within a block

    // RAMFILE address source selected by the CROM
    typedef enum logic [1:0] {
        RAM_SEL_AC  = 2'd0,
        RAM_SEL_XR  = 2'd1,
        RAM_SEL_VMA = 2'd2,
        RAM_SEL_NUM = 2'd3
    } ram_sel_t;

    // RAMFILE controller state
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Odd parity: returns the bit that makes the total count of ones odd.
    function automatic logic odd_par(input logic [c_DATA_W-1:0] d);
        return ~(^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramfile_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ramfile_unit_if
//  Description : Bus bundle between the microsequencer/datapath and the
//                RAMFILE. The master drives the address selects, AC/XR
//                numbers, VMA, CROM number, write strobe and DBUS data; the
//                slave (RAMFILE) returns the read word, busy, and parERR when
//                RAMFILE_PARITY_EN is defined.
//  Ports       : ramWR, addrSEL, usePREV, curBLOCK, prevBLOCK, acNUM, xrNUM,
//                vma, cromNUM, dbus  (master -> slave)
//                ramfile, busy, [parERR]  (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface ramfile_unit_if
    import ks10_ramfile_pkg::*;
;
    logic                  ramWR;
    ram_sel_t              addrSEL;
    logic                  usePREV;
    logic [c_BLK_W-1:0]    curBLOCK;
    logic [c_BLK_W-1:0]    prevBLOCK;
    logic [c_NUM_W-1:0]    acNUM;
    logic [c_NUM_W-1:0]    xrNUM;
    logic [c_ADDR_W-1:0]   vma;
    logic [c_ADDR_W-1:0]   cromNUM;
    logic [c_DATA_W-1:0]   dbus;
    logic [c_DATA_W-1:0]   ramfile;
    logic                  busy;
`ifdef RAMFILE_PARITY_EN
    logic                  parERR;
`endif

    modport master (
        output ramWR, addrSEL, usePREV, curBLOCK, prevBLOCK,
               acNUM, xrNUM, vma, cromNUM, dbus,
        input  ramfile, busy
`ifdef RAMFILE_PARITY_EN
        , input parERR
`endif
    );

    modport slave (
        input  ramWR, addrSEL, usePREV, curBLOCK, prevBLOCK,
               acNUM, xrNUM, vma, cromNUM, dbus,
        output ramfile, busy
`ifdef RAMFILE_PARITY_EN
        , output parERR
`endif
    );

endinterface
`default_nettype wire

// File: rtl/ramfile_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ramfile_mem
//  Description : Single-port synchronous RAM with registered address and
//                write-first behaviour: a write and a read of the same
//                address in one cycle return the new data after the edge.
//                Written in the template that synthesis maps to block RAM.
//  Ports       : clk     clock
//                i_we    write enable
//                i_addr  read/write address
//                i_din   write data
//                o_dout  data at the address registered on the last edge
//  Revision    : 1.0  initial release
// ============================================================================
module ramfile_mem #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 36
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [WIDTH-1:0]  i_din,
    output logic      [WIDTH-1:0]  o_dout
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_addr;

    // Contents are deliberately not reset; the owner zero-fills them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        r_addr <= i_addr;
    end

    // Reading through the registered address yields write-first data.
    assign o_dout = r_mem[r_addr];

endmodule
`default_nettype wire

// File: rtl/ramfile_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ramfile_unit
//  Description : KS-10 RAMFILE, 1024 x 36: the eight blocks of fast ACs plus
//                microcode workspace. Forms the RAMFILE address from the CROM
//                select, AC/XR numbers, VMA and AC block; writes DBUS data
//                on ramWR; zero-fills the whole array after reset.
//                Optional macro RAMFILE_PARITY_EN adds a stored odd-parity
//                bit and a registered parERR output.
//  Ports       : clk    system clock
//                rst_n  synchronous active-low reset
//                bus    ramfile_unit_if.slave (selects, numbers, vma,
//                       cromNUM, dbus, ramWR in; ramfile, busy, [parERR] out)
//  Revision    : 1.0  initial release
// ============================================================================
module ramfile_unit
    import ks10_ramfile_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W,
    parameter int DATA_W         = c_DATA_W,
    parameter bit CLR_EN_DEFAULT = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    ramfile_unit_if.slave  bus
);

`ifdef RAMFILE_PARITY_EN
    localparam int c_MEM_W = DATA_W + 1;
`else
    localparam int c_MEM_W = DATA_W;
`endif
    localparam int c_HI_W = ADDR_W - c_BLK_W - c_NUM_W;

    rf_state_t           r_state;
    rf_state_t           w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                r_rd_valid;

    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_mem_we;
    logic [c_MEM_W-1:0]  w_mem_din;
    logic [c_MEM_W-1:0]  w_mem_dout;

    // ------------------------------------------------------------------
    // Address formation. Each select arm touches only its own inputs so
    // X on an unselected source cannot leak into the address.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr = '0;
        case (bus.addrSEL)
            RAM_SEL_AC: begin
                w_addr = {{c_HI_W{1'b0}},
                          (bus.usePREV ? bus.prevBLOCK : bus.curBLOCK),
                          bus.acNUM};
            end
            RAM_SEL_XR: begin
                w_addr = {{c_HI_W{1'b0}},
                          (bus.usePREV ? bus.prevBLOCK : bus.curBLOCK),
                          bus.xrNUM};
            end
            RAM_SEL_VMA: begin
                // VMA 0..17 is a fast-AC reference, always in the current block
                if (bus.vma[ADDR_W-1:c_NUM_W] == '0) begin
                    w_addr = {{c_HI_W{1'b0}}, bus.curBLOCK, bus.vma[c_NUM_W-1:0]};
                end else begin
                    w_addr = bus.vma;
                end
            end
            RAM_SEL_NUM: begin
                w_addr = bus.cromNUM;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CLEAR / RUN controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (CLR_EN_DEFAULT) begin
                r_state <= RF_CLEAR;
            end else begin
                r_state <= RF_RUN;
            end
            r_clr_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            // Read data is meaningful only for addresses registered in RUN
            r_rd_valid <= (r_state == RF_RUN);
        end
    end

    // ------------------------------------------------------------------
    // CLEAR / RUN controller: next state and RAM port steering
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_mem_we      = 1'b0;
        w_mem_addr    = w_addr;
`ifdef RAMFILE_PARITY_EN
        w_mem_din     = {odd_par(bus.dbus), bus.dbus};
`else
        w_mem_din     = bus.dbus;
`endif
        case (r_state)
            RF_CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_cnt;
`ifdef RAMFILE_PARITY_EN
                w_mem_din     = {1'b1, {DATA_W{1'b0}}};
`else
                w_mem_din     = '0;
`endif
                // Counter wraps to 0 on the same edge that enters RUN
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                w_mem_we = bus.ramWR;
            end
            default: begin
                w_state_nxt = RF_CLEAR;
            end
        endcase
        // No writes while reset is held, so reset alone never alters contents
        w_mem_we = w_mem_we & rst_n;
    end

    ramfile_mem #(
        .ADDR_W (ADDR_W),
        .WIDTH  (c_MEM_W)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_addr (w_mem_addr),
        .i_din  (w_mem_din),
        .o_dout (w_mem_dout)
    );

    assign bus.ramfile = r_rd_valid ? w_mem_dout[DATA_W-1:0] : '0;
    assign bus.busy    = (r_state == RF_CLEAR);

`ifdef RAMFILE_PARITY_EN
    logic r_par_err;

    // Checks the word currently on the read port; data is passed on regardless
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= r_rd_valid &&
                         (w_mem_dout[DATA_W] != odd_par(w_mem_dout[DATA_W-1:0]));
        end
    end

    assign bus.parERR = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ramfile_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ramfile_unit
//  Description : Self-checking bench for ramfile_unit: reset/zero-fill timing,
//                a table of directed write/read vectors covering every
//                address select, and hand-written reset and parity sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ramfile_unit;
    import ks10_ramfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ramfile_unit_if bus ();

    ramfile_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        ram_sel_t     sel;
        logic         use_prev;
        logic [2:0]   cur;
        logic [2:0]   prev;
        logic [3:0]   ac;
        logic [3:0]   xr;
        logic [9:0]   vma;
        logic [9:0]   crom;
        logic         wr;
        logic [35:0]  dbus;
        logic [35:0]  exp;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t vecs [c_NVEC];

    int n_pass  = 0;
    int n_total = 0;
    int busy_cycles;
    logic zero_ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input ram_sel_t sel, input logic up, input logic [2:0] cur,
                                input logic [2:0] prev, input logic [3:0] ac, input logic [3:0] xr,
                                input logic [9:0] vma, input logic [9:0] crom, input logic wr,
                                input logic [35:0] d, input logic [35:0] e);
        vec_t v;
        v.sel = sel; v.use_prev = up; v.cur = cur; v.prev = prev; v.ac = ac; v.xr = xr;
        v.vma = vma; v.crom = crom; v.wr = wr; v.dbus = d; v.exp = e;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.ramWR = 1'b0; bus.addrSEL = RAM_SEL_NUM; bus.usePREV = 1'b0;
        bus.curBLOCK = 3'd0; bus.prevBLOCK = 3'd0; bus.acNUM = 4'd0; bus.xrNUM = 4'd0;
        bus.vma = 10'd0; bus.cromNUM = 10'd0; bus.dbus = 36'd0;
    endtask

    // Counts edges after reset release until busy drops; checks ramfile=0
    // meanwhile and optionally tries a write at cycle 500.
    task automatic measure_busy(input bit poke500, output int n);
        n = 0;
        zero_ok = 1'b1;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ramfile !== 36'd0) zero_ok = 1'b0;
            if (!bus.busy) break;
            if (poke500 && n == 499) begin
                bus.ramWR = 1'b1; bus.addrSEL = RAM_SEL_NUM; bus.cromNUM = 10'd5;
                bus.dbus = 36'o777777777777;
            end else if (poke500 && n == 500) begin
                bus.cromNUM = 10'd500;
            end else if (poke500 && n == 501) begin
                idle_inputs();
            end
        end
    endtask

    task automatic apply_vec(input int i);
        @(negedge clk);
        bus.addrSEL = vecs[i].sel;  bus.usePREV = vecs[i].use_prev;
        bus.curBLOCK = vecs[i].cur; bus.prevBLOCK = vecs[i].prev;
        bus.acNUM = vecs[i].ac;     bus.xrNUM = vecs[i].xr;
        bus.vma = vecs[i].vma;      bus.cromNUM = vecs[i].crom;
        bus.ramWR = vecs[i].wr;     bus.dbus = vecs[i].dbus;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d ramfile", i), {28'd0, bus.ramfile}, {28'd0, vecs[i].exp});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sel          up cur   prev  ac    xr    vma      crom     wr dbus              exp
        vecs[0]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'd500, 0, 36'd0,            36'd0);
        vecs[1]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'd5,   0, 36'd0,            36'd0);
        vecs[2]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3F0, 1, 36'o123456701234, 36'o123456701234);
        vecs[3]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3F0, 0, 36'd0,            36'o123456701234);
        vecs[4]  = mk(RAM_SEL_AC,  0, 3'd3, 3'd5, 4'h7, 4'h0, 10'h000, 10'h000, 1, 36'o1,            36'o1);
        vecs[5]  = mk(RAM_SEL_AC,  1, 3'd3, 3'd5, 4'h7, 4'h0, 10'h000, 10'h000, 1, 36'o2,            36'o2);
        vecs[6]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h037, 0, 36'd0,            36'o1);
        vecs[7]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h057, 0, 36'd0,            36'o2);
        vecs[8]  = mk(RAM_SEL_XR,  1, 3'd3, 3'd5, 4'h0, 4'h9, 10'h000, 10'h000, 1, 36'o777,          36'o777);
        vecs[9]  = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h059, 0, 36'd0,            36'o777);
        vecs[10] = mk(RAM_SEL_XR,  0, 3'd3, 3'd5, 4'h0, 4'h9, 10'h000, 10'h000, 0, 36'd0,            36'd0);
        vecs[11] = mk(RAM_SEL_VMA, 0, 3'd2, 3'd0, 4'h0, 4'h0, 10'h00A, 10'h000, 1, 36'o4444,         36'o4444);
        vecs[12] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h02A, 0, 36'd0,            36'o4444);
        vecs[13] = mk(RAM_SEL_VMA, 0, 3'd2, 3'd0, 4'h0, 4'h0, 10'h04A, 10'h000, 1, 36'o5555,         36'o5555);
        vecs[14] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h04A, 0, 36'd0,            36'o5555);
        vecs[15] = mk(RAM_SEL_VMA, 1, 3'd3, 3'd2, 4'h0, 4'h0, 10'h00A, 10'h000, 0, 36'd0,            36'd0);
        vecs[16] = mk(RAM_SEL_AC,  1, 3'd3, 3'd2, 4'hA, 4'h0, 10'h000, 10'h000, 0, 36'd0,            36'o4444);
        vecs[17] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3F0, 0, 36'd0,            36'o123456701234);
        vecs[17].ac = 'x; vecs[17].xr = 'x; vecs[17].vma = 'x; vecs[17].use_prev = 'x;
        vecs[18] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3FF, 1, 36'o777777777777, 36'o777777777777);
        vecs[19] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3F0, 0, 36'd0,            36'o123456701234);
        vecs[20] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3FF, 0, 36'd0,            36'o777777777777);

        // ---------------- reset and initial zero-fill ----------------
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, bus.busy}, 64'd1);
        check("reset ramfile", {28'd0, bus.ramfile}, 64'd0);
`ifdef RAMFILE_PARITY_EN
        check("reset parERR", {63'd0, bus.parERR}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy(1'b1, busy_cycles);
        check("clear length", 64'(busy_cycles), 64'd1024);
        check("clear ramfile zero", {63'd0, zero_ok}, 64'd1);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < c_NVEC; i++) begin
            apply_vec(i);
        end
        @(negedge clk);
        idle_inputs();
        check("run busy low", {63'd0, bus.busy}, 64'd0);

`ifdef RAMFILE_PARITY_EN
        // ---------------- parity error injection ----------------
        bus.addrSEL = RAM_SEL_NUM; bus.cromNUM = 10'h100; bus.ramWR = 1'b1;
        bus.dbus = 36'o010203040506;
        @(negedge clk);
        bus.ramWR = 1'b0; bus.cromNUM = 10'h101;
        @(negedge clk);
        dut.u_mem.r_mem[10'h100][36] = ~dut.u_mem.r_mem[10'h100][36];
        bus.cromNUM = 10'h100;
        @(posedge clk); #1;
        check("par data", {28'd0, bus.ramfile}, {28'd0, 36'o010203040506});
        check("par before", {63'd0, bus.parERR}, 64'd0);
        @(negedge clk);
        bus.cromNUM = 10'h101;
        @(posedge clk); #1;
        check("par err", {63'd0, bus.parERR}, 64'd1);
        @(posedge clk); #1;
        check("par err one cycle", {63'd0, bus.parERR}, 64'd0);
        @(negedge clk);
`endif

        // ---------------- reset in the middle of CLEAR ----------------
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rerun reset busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy(1'b0, busy_cycles);
        // Released again; now interrupt the fill at cycle 300
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rerun2 busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("mid clear busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid clear reset ramfile", {28'd0, bus.ramfile}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy(1'b0, busy_cycles);
        check("restart clear length", 64'(busy_cycles), 64'd1024);
        check("restart ramfile zero", {63'd0, zero_ok}, 64'd1);

        // Contents written earlier must be wiped by the fill
        vecs[0] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3F0, 0, 36'd0, 36'd0);
        vecs[1] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h037, 0, 36'd0, 36'd0);
        vecs[2] = mk(RAM_SEL_NUM, 0, 3'd0, 3'd0, 4'h0, 4'h0, 10'h000, 10'h3FF, 0, 36'd0, 36'd0);
        for (int i = 0; i < 3; i++) begin
            apply_vec(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
